// File: rtl/store_rmw_unit_pkg.sv
// Shared CPU definitions used by the store and load paths.
//   - store_size_e : access size encoding carried on req_size
//   - rmw_state_e  : state encoding of the store read-modify-write FSM
//   - is_misaligned: alignment rule for a size / low address pair
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } store_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } rmw_state_e;

    // Illegal size, odd halfword address or non-word-aligned word address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_rmw_unit_merge.sv
// byte_lane_merge: combinational merge of store data into a memory word.
//   old_word [31:0] : word read back from memory
//   new_data [31:0] : store data, payload in the low-order bits
//   size     [1:0]  : access size (store_size_e encoding)
//   addr_lo  [1:0]  : low byte-address bits selecting the lane(s)
//   merged   [31:0] : old_word with the addressed lane(s) replaced
module byte_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    // Replace the addressed byte or halfword lane; everything else keeps old_word.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    2'd3:    merged[31:24] = new_data[7:0];
                    default: merged        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = new_data[15:0];
                end else begin
                    merged[15:0]  = new_data[15:0];
                end
            end
            // Full-word stores never go through the merge path; pass data through.
            SZ_WORD: merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: store path onto a word-wide synchronous RAM. Word stores
// write directly; byte/halfword stores read the word, merge, and write back.
// Misaligned or illegal-size requests are rejected with a misalign pulse.
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only when idle)
//   req_addr/req_data/req_size: byte address, store data, access size
//   done, misalign           : one-cycle completion / rejection pulses
//   mem_addr                 : word address of the latched request
//   mem_rd_en/mem_rdata      : read strobe, data returned the following cycle
//   mem_wr_en/mem_wdata      : write strobe and word to write
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic                  done,
    output logic                  misalign,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    rmw_state_e            state_r;
    rmw_state_e            state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [1:0]            size_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  accept_s;

    assign accept_s = (state_r == ST_IDLE) && req_valid;

    byte_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (data_r),
        .size     (size_r),
        .addr_lo  (addr_r[1:0]),
        .merged   (merged_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_s = ST_IDLE;
                end else if (is_misaligned(req_size, req_addr[1:0])) begin
                    state_s = ST_ERR;
                end else if (req_size == SZ_WORD) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ:  state_s = ST_WAIT;
            ST_WAIT:  state_s = ST_WRITE;
            ST_WRITE: state_s = ST_IDLE;
            ST_ERR:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Request latch and write-data register; word data is loaded at acceptance,
    // merged data is captured in WAIT when mem_rdata is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            size_r  <= 2'b00;
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            addr_r  <= req_addr;
            data_r  <= req_data;
            size_r  <= req_size;
            wdata_r <= req_data;
        end else if (state_r == ST_WAIT) begin
            wdata_r <= merged_s;
        end
    end

    // Address and write data come straight from registers, so they stay
    // stable from READ through WRITE.
    assign mem_addr  = addr_r[ADDR_WIDTH-1:2];
    assign mem_wdata = wdata_r;

    // Output decode from the state register only.
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        misalign  = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        case (state_r)
            ST_IDLE:  req_ready = 1'b1;
            ST_READ:  mem_rd_en = 1'b1;
            ST_WAIT:  req_ready = 1'b0;
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
            end
            ST_ERR:   misalign = 1'b1;
            default:  req_ready = 1'b0;
        endcase
    end

endmodule

// File: doc/store_rmw_unit.md
STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of req_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width; fixed at 32 for this revision.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req_valid, input, 1, store request present.
REQ-006 Port req_ready, output, 1, unit idle and able to accept a request.
REQ-007 Port req_addr, input, ADDR_WIDTH, byte address of store.
REQ-008 Port req_data, input, 32, store data in low-order bits.
REQ-009 Port req_size, input, 2, size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Port done, output, 1, one-cycle pulse marking store completion.
REQ-011 Port misalign, output, 1, one-cycle pulse marking a rejected request.
REQ-012 Port mem_addr, output, ADDR_WIDTH-2, word address, equal to req_addr[ADDR_WIDTH-1:2].
REQ-013 Port mem_rd_en, output, 1, word read strobe; mem_rdata is valid on the following cycle.
REQ-014 Port mem_rdata, input, 32, read word from synchronous RAM.
REQ-015 Port mem_wr_en, output, 1, word write strobe.
REQ-016 Port mem_wdata, output, 32, word to write.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WAIT, WRITE, ERR.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019 On acceptance, addr, data and size SHALL be latched; inputs SHALL be ignored until the FSM returns to IDLE.
REQ-020 A request SHALL be misaligned when size=11, when size=01 with addr[0]=1, or when size=10 with addr[1:0]!=0; IDLE SHALL then go to ERR.
REQ-021 ERR SHALL assert misalign for one cycle with no memory strobes, then return to IDLE.
REQ-022 An aligned word request SHALL go IDLE->WRITE; mem_wdata SHALL equal the latched data.
REQ-023 An aligned byte or halfword request SHALL go IDLE->READ->WAIT->WRITE.
REQ-024 READ SHALL assert mem_rd_en for exactly one cycle.
REQ-025 WAIT SHALL register the merged word.
  - Byte: lane addr[1:0] (bits 8k+7:8k) is replaced by data[7:0].
  - Halfword: bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1) are replaced by data[15:0].
  - All other bits keep the mem_rdata value.
REQ-026 WRITE SHALL assert mem_wr_en and done together for exactly one cycle, then return to IDLE.
REQ-027 Latency from acceptance edge T SHALL be: word, done in cycle T+1; byte/half, done in cycle T+3; misaligned, misalign in cycle T+1.
REQ-028 Back-to-back requests SHALL be possible: req_ready is 1 in the cycle after done or misalign.
REQ-029 mem_addr SHALL be held stable from READ through WRITE.
REQ-030 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle.
REQ-031 The unit SHALL never write to memory for a misaligned request.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE from any state, including an in-flight READ, WAIT or WRITE.
REQ-033 During reset, and in the first cycle after it, outputs SHALL be: req_ready=1, done=0, misalign=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-034 An operation aborted by reset SHALL issue no later mem_wr_en.

Structure
REQ-035 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encodings SHALL reside in the shared CPU definitions package/header, which is also used by the load path.
REQ-036 The merge logic SHALL be a combinational sub-module, byte_lane_merge (inputs old word, new data, size, addr[1:0]; output merged word).

Verification
REQ-037 Word store: addr=0x100, data=0xDEADBEEF, size=10 -> cycle T+1: mem_wr_en=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never asserted.
REQ-038 Byte store: addr=0x103, data=0x000000AB, size=00, mem_rdata=0x11223344 -> cycle T+3: mem_wdata=0xAB223344, done=1.
REQ-039 Halfword store: addr=0x102, data=0x0000CAFE, size=01, mem_rdata=0x11223344 -> mem_wdata=0xCAFE3344; then addr=0x100 with the same inputs -> mem_wdata=0x1122CAFE.
REQ-040 Misaligned requests: addr=0x101 size=01; addr=0x102 size=10; size=11 -> misalign=1 at T+1, no mem_rd_en or mem_wr_en, req_ready=1 at T+2.
REQ-041 Reset in WAIT: byte store accepted, rst=1 in cycle T+2 -> mem_wr_en stays 0, done stays 0, req_ready=1 after reset.
REQ-042 Back-to-back: req_valid held high with two word stores -> done asserted at T+1 and T+3; second mem_wdata equals the second data.
